// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the register-array FIFO family.
//   FIFO_MODE_STD / FIFO_MODE_FWFT : read-mode selectors for the FWFT parameter
//   FIFO_DEF_AE_THRESH             : default almost-empty threshold
//   FIFO_DEF_AF_MARGIN             : default almost-full distance below DEPTH
//   fifo_clog2()                   : ceil(log2(v)), 0 for v <= 1
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned FIFO_MODE_STD      = 0;
    localparam int unsigned FIFO_MODE_FWFT     = 1;

    localparam int unsigned FIFO_DEF_AE_THRESH = 2;
    localparam int unsigned FIFO_DEF_AF_MARGIN = 2;

    localparam int unsigned FIFO_MIN_AWIDTH    = 2;
    localparam int unsigned FIFO_MAX_AWIDTH    = 6;

    // Ceiling log2, usable in parameter expressions of FIFO variants
    function automatic int unsigned fifo_clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_reg_flex_mem.sv
// ----------------------------------------------------------------------------
// fifo_reg_flex_mem
// DEPTH x DWIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// ----------------------------------------------------------------------------
module fifo_reg_flex_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] r_mem [DEPTH];

    // Write port; a same-address read in this cycle still sees the old word
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port
    assign rdata = r_mem[raddr];

endmodule : fifo_reg_flex_mem

// File: rtl/fifo_reg_flex.sv
// ----------------------------------------------------------------------------
// fifo_reg_flex
// Single-clock register-array FIFO with selectable read mode (registered or
// first-word-fall-through), programmable almost-full/almost-empty thresholds,
// full-range occupancy count, overflow/underflow pulses and synchronous flush.
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr           : synchronous flush (priority over rd/wr)
//   wr, wdata     : write request and data
//   rd            : read request (pop acknowledge in FWFT mode)
//   rdata, rvalid : read data and its valid
//   full, empty   : count == DEPTH / count == 0
//   almost_full   : count >= AF_THRESH
//   almost_empty  : count <= AE_THRESH
//   data_cnt      : occupancy 0..DEPTH
//   overflow      : one-cycle pulse, write refused
//   underflow     : one-cycle pulse, read refused
// ----------------------------------------------------------------------------
module fifo_reg_flex
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned AWIDTH    = 4,
    parameter int unsigned AF_THRESH = (1 << AWIDTH) - FIFO_DEF_AF_MARGIN,
    parameter int unsigned AE_THRESH = FIFO_DEF_AE_THRESH,
    parameter int unsigned FWFT      = FIFO_MODE_STD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              rd,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   data_cnt,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned DEPTH = 1 << AWIDTH;
    localparam int unsigned CW    = AWIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]     r_cnt;
    logic              r_full;
    logic              r_empty;
    logic              r_af;
    logic              r_ae;
    logic              r_ov;
    logic              r_un;

    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [CW-1:0]     w_cnt_nxt;
    logic [DWIDTH-1:0] w_mem_rdata;

    // Acceptance: a write at full is allowed when a pop frees a slot this cycle.
    // A flush suppresses both operations (and their error pulses).
    always_comb begin
        w_wr_ok   = wr & (~r_full | rd);
        w_rd_ok   = rd & ~r_empty;
        w_wr_en   = w_wr_ok & ~clr;
        w_rd_en   = w_rd_ok & ~clr;
        w_cnt_nxt = r_cnt;
        if (clr) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + CW'(w_wr_en) - CW'(w_rd_en);
        end
    end

    // Pointers, count, flags and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ov     <= 1'b0;
            r_un     <= 1'b0;
        end else begin
            if (clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + AWIDTH'(w_wr_en);
                r_rd_ptr <= r_rd_ptr + AWIDTH'(w_rd_en);
            end
            r_cnt   <= w_cnt_nxt;
            // Flags come from the next count so they always agree with data_cnt
            r_full  <= (w_cnt_nxt == DEPTH_C);
            r_empty <= (w_cnt_nxt == '0);
            r_af    <= (w_cnt_nxt >= AF_C);
            r_ae    <= (w_cnt_nxt <= AE_C);
            r_ov    <= ~clr & wr & ~w_wr_ok;
            r_un    <= ~clr & rd & ~w_rd_ok;
        end
    end

    fifo_reg_flex_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_en),
        .waddr (r_wr_ptr),
        .wdata (wdata),
        .raddr (r_rd_ptr),
        .rdata (w_mem_rdata)
    );

    // Read-mode output path
    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            // Head word is visible as soon as registered empty drops
            assign rdata  = w_mem_rdata;
            assign rvalid = ~r_empty;
        end else begin : g_std
            logic [DWIDTH-1:0] r_rdata;
            logic              r_rvalid;

            // One-cycle read latency; rdata holds between reads
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else if (clr) begin
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_en;
                    if (w_rd_en) begin
                        r_rdata <= w_mem_rdata;
                    end
                end
            end

            assign rdata  = r_rdata;
            assign rvalid = r_rvalid;
        end
    endgenerate

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign data_cnt     = r_cnt;
    assign overflow     = r_ov;
    assign underflow    = r_un;

endmodule : fifo_reg_flex
